// File: rtl/qencoder_gen2.sv
// Quadrature decoder: sync + glitch filter, x1/x2/x4 position, windowed velocity; QENC_INDEX_EN adds index load.
// Latency: pin to filtered 2+NF cycles, position one cycle later; no backpressure, outputs are free-running.
module qencoder_gen2 #(
    parameter int NB     = 32,
    parameter int NF     = 4,
    parameter int NV     = 16,
    parameter int PERIOD = 1000
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [1:0]           i_encoder,
    input  logic                 i_index,
    input  logic [1:0]           i_mode,
    input  logic                 i_clear,
    output logic [NB-1:0]        o_position,
    output logic                 o_dir,
    output logic [NV-1:0]        o_velocity,
    output logic                 o_vel_valid,
    output logic                 o_error,
    output logic                 o_index_seen
);
    localparam int CW = (NF > 1) ? $clog2(NF) : 1;
    localparam int WW = $clog2(PERIOD);

    logic [1:0]          enc_s1_q, enc_s1_d, enc_s2_q, enc_s2_d;
    logic [1:0]          filt_q, filt_d, prev_q, prev_d;
    logic [1:0][CW-1:0]  fcnt_q, fcnt_d;
    logic [NB-1:0]       pos_q, pos_d;
    logic                dir_q, dir_d;
    logic [NV-1:0]       acc_q, acc_d, vel_q, vel_d, acc_sat;
    logic [WW-1:0]       win_q, win_d;
    logic                vld_q, vld_d, err_q, err_d;
    logic [NV:0]         sum;
    logic                both, a_chg, fwd, cnt_en, step, up, dn, last, idx_load;

    // Gray position of {A,B} along the forward sequence 00,10,11,01.
    function automatic logic [1:0] gidx(input logic [1:0] s);
        return {s[0], s[1] ^ s[0]};
    endfunction

`ifdef QENC_INDEX_EN
    logic idx_s1_q, idx_s1_d, idx_s2_q, idx_s2_d, idx_prev_q, idx_prev_d, seen_q, seen_d;
    assign idx_load     = idx_s2_q & ~idx_prev_q & i_enable;
    assign o_index_seen = seen_q;
`else
    logic unused_index;
    assign unused_index = i_index;
    assign idx_load     = 1'b0;
    assign o_index_seen = 1'b0;
`endif

    always_comb begin
        enc_s1_d = i_encoder;
        enc_s2_d = enc_s1_q;
        filt_d   = filt_q;
        fcnt_d   = fcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (enc_s2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == CW'(NF - 1)) begin
                    filt_d[i] = enc_s2_q[i];
                    fcnt_d[i] = '0;
                end else begin
                    fcnt_d[i] = fcnt_q[i] + CW'(1);
                end
            end else begin
                fcnt_d[i] = '0;
            end
        end
        prev_d = filt_q;

        both  = &(filt_q ^ prev_q);
        a_chg = filt_q[1] ^ prev_q[1];
        fwd   = (gidx(filt_q) == gidx(prev_q) + 2'd1);
        case (i_mode)
            2'b00:   cnt_en = ((prev_q == 2'b10) && (filt_q == 2'b11)) ||
                              ((prev_q == 2'b11) && (filt_q == 2'b10));
            2'b01:   cnt_en = a_chg & ~both;
            default: cnt_en = (filt_q != prev_q) & ~both;
        endcase
        step = cnt_en & i_enable & ~i_clear & ~idx_load;
        up   = step & fwd;
        dn   = step & ~fwd;

        if (i_clear || idx_load) pos_d = '0;
        else if (up)             pos_d = pos_q + NB'(1);
        else if (dn)             pos_d = pos_q - NB'(1);
        else                     pos_d = pos_q;
        dir_d = step ? fwd : dir_q;

        // One extra bit of headroom; a sign mismatch between the top two bits means overflow.
        sum = {acc_q[NV-1], acc_q} + {{NV{dn}}, (up | dn)};
        if (sum[NV] != sum[NV-1]) acc_sat = sum[NV] ? {1'b1, {(NV-1){1'b0}}} : {1'b0, {(NV-1){1'b1}}};
        else                      acc_sat = sum[NV-1:0];

        last  = (win_q == WW'(PERIOD - 1));
        vld_d = last & i_enable & ~i_clear;
        vel_d = vld_d ? acc_sat : vel_q;
        if (i_clear) begin
            win_d = '0;
            acc_d = '0;
        end else if (i_enable) begin
            win_d = last ? '0 : win_q + WW'(1);
            acc_d = last ? '0 : acc_sat;
        end else begin
            win_d = win_q;
            acc_d = acc_q;
        end
        err_d = ~i_clear & (err_q | both);

`ifdef QENC_INDEX_EN
        idx_s1_d   = i_index;
        idx_s2_d   = idx_s1_q;
        idx_prev_d = idx_s2_q;
        seen_d     = ~i_clear & (seen_q | idx_load);
`endif
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            enc_s1_q <= '0;
            enc_s2_q <= '0;
            filt_q   <= '0;
            prev_q   <= '0;
            fcnt_q   <= '0;
            pos_q    <= '0;
            dir_q    <= 1'b0;
            acc_q    <= '0;
            vel_q    <= '0;
            win_q    <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef QENC_INDEX_EN
            idx_s1_q   <= 1'b0;
            idx_s2_q   <= 1'b0;
            idx_prev_q <= 1'b0;
            seen_q     <= 1'b0;
`endif
        end else begin
            enc_s1_q <= enc_s1_d;
            enc_s2_q <= enc_s2_d;
            filt_q   <= filt_d;
            prev_q   <= prev_d;
            fcnt_q   <= fcnt_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            acc_q    <= acc_d;
            vel_q    <= vel_d;
            win_q    <= win_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
`ifdef QENC_INDEX_EN
            idx_s1_q   <= idx_s1_d;
            idx_s2_q   <= idx_s2_d;
            idx_prev_q <= idx_prev_d;
            seen_q     <= seen_d;
`endif
        end
    end

    assign o_position  = pos_q;
    assign o_dir       = dir_q;
    assign o_velocity  = vel_q;
    assign o_vel_valid = vld_q;
    assign o_error     = err_q;
endmodule
